// File: rtl/face_pkg.sv
// Shared constants and state encoding for the face-match classifier slice.
package face_pkg;

    localparam int unsigned LAT_SUB = 7;
    localparam int unsigned LAT_MUL = 5;
    localparam int unsigned LAT_ADD = 7;

    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, SUB, MUL, ACC, NEXT, CMP, DONE
    } state_t;

endpackage

// File: rtl/FP_AddSub.sv
// Single-precision add/subtract with a fixed LAT-cycle pipeline.
// add_sub: 0 = dataa - datab, 1 = dataa + datab. Subnormals flush to zero,
// rounding is to nearest even. aclr clears the pipeline on the clock edge.
module FP_AddSub import face_pkg::*; #(
    parameter int unsigned LAT = 7
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        add_sub,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0] bEff, x, y, resC;
    logic [7:0]  dExp;
    logic [5:0]  shamt;
    logic [47:0] mx, myFull, my, n;
    logic [48:0] s;
    logic [22:0] frac;
    logic        lost, rup, carry, nanA, nanB, infA, infB;
    int          lz, e;
    logic [31:0] pipe [LAT];

    // Align, add/subtract, normalise and round
    always_comb begin
        bEff   = {datab[31] ^ ~add_sub, datab[30:0]};
        nanA   = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
        nanB   = (bEff[30:23] == 8'hFF) && (bEff[22:0] != 23'd0);
        infA   = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
        infB   = (bEff[30:23] == 8'hFF) && (bEff[22:0] == 23'd0);
        x      = (bEff[30:0] > dataa[30:0]) ? bEff : dataa;
        y      = (bEff[30:0] > dataa[30:0]) ? dataa : bEff;
        dExp   = x[30:23] - y[30:23];
        shamt  = (dExp > 8'd48) ? 6'd48 : dExp[5:0];
        mx     = {1'b1, x[22:0], 24'd0};
        myFull = {1'b1, y[22:0], 24'd0};
        lost   = (myFull & ((48'd1 << shamt) - 48'd1)) != 48'd0;
        my     = (myFull >> shamt) | 48'(lost);
        s      = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        lz     = 0;
        for (int i = 0; i < 49; i++) begin
            if (s[i]) lz = 48 - i;
        end
        // Hidden bit lands in bit 48 and is dropped by the truncation.
        n      = 48'(s << lz);
        rup    = n[24] && ((n[23:0] != 24'd0) || n[25]);
        {carry, frac} = {1'b0, n[47:25]} + 24'(rup);
        e      = int'(x[30:23]) + 1 - lz + int'(carry);
        if (nanA || nanB || (infA && infB && (dataa[31] != bEff[31])))
            resC = FP_QNAN;
        else if (infA || infB)
            resC = {x[31], 8'hFF, 23'd0};
        else if (x[30:23] == 8'd0)
            resC = {x[31] & y[31], 31'd0};
        else if (y[30:23] == 8'd0)
            resC = x;
        else if (s == 49'd0)
            resC = 32'd0;
        else if (e >= 255)
            resC = {x[31], 8'hFF, 23'd0};
        else if (e <= 0)
            resC = {x[31], 31'd0};
        else
            resC = {x[31], 8'(e), frac};
    end

    // Fixed-latency result pipeline
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= resC;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];

endmodule

// File: rtl/FP_Mult.sv
// Single-precision multiply with a fixed LAT-cycle pipeline.
// Subnormals flush to zero, rounding is to nearest even.
module FP_Mult import face_pkg::*; #(
    parameter int unsigned LAT = 5
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [47:0] prod;
    logic [46:0] norm;
    logic [22:0] frac;
    logic [31:0] resC;
    logic        sgn, rup, carry, nanA, nanB, infA, infB, zeroA, zeroB;
    int          e;
    logic [31:0] pipe [LAT];

    // Mantissa product, normalise and round
    always_comb begin
        sgn   = dataa[31] ^ datab[31];
        nanA  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
        nanB  = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
        infA  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
        infB  = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
        zeroA = dataa[30:23] == 8'd0;
        zeroB = datab[30:23] == 8'd0;
        prod  = 48'({1'b1, dataa[22:0]}) * 48'({1'b1, datab[22:0]});
        // Hidden bit is dropped; norm holds fraction, guard and sticky bits.
        norm  = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
        rup   = norm[23] && ((norm[22:0] != 23'd0) || norm[24]);
        {carry, frac} = {1'b0, norm[46:24]} + 24'(rup);
        e     = int'(dataa[30:23]) + int'(datab[30:23]) - 127 + int'(prod[47]) + int'(carry);
        if (nanA || nanB || (infA && zeroB) || (infB && zeroA))
            resC = FP_QNAN;
        else if (infA || infB)
            resC = {sgn, 8'hFF, 23'd0};
        else if (zeroA || zeroB || (e <= 0))
            resC = {sgn, 31'd0};
        else if (e >= 255)
            resC = {sgn, 8'hFF, 23'd0};
        else
            resC = {sgn, 8'(e), frac};
    end

    // Fixed-latency result pipeline
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= resC;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];

endmodule

// File: rtl/fp_sqdiff_acc.sv
// acc_out = acc_in + (a - b)^2, as a chain of three pipelined FP operators.
// The caller holds each stage's inputs stable for that stage's latency.
module fp_sqdiff_acc import face_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc_in,
    output logic [31:0] acc_out
);

    logic [31:0] diff;
    logic [31:0] sq;

    FP_AddSub #(.LAT(LAT_SUB)) uSub (
        .clk(clk), .aclr(rst), .add_sub(1'b0), .dataa(a), .datab(b), .result(diff)
    );

    FP_Mult #(.LAT(LAT_MUL)) uMul (
        .clk(clk), .aclr(rst), .dataa(diff), .datab(diff), .result(sq)
    );

    FP_AddSub #(.LAT(LAT_ADD)) uAdd (
        .clk(clk), .aclr(rst), .add_sub(1'b1), .dataa(acc_in), .datab(sq), .result(acc_out)
    );

endmodule

// File: rtl/dist_classifier.sv
// Nearest-neighbour classifier: squared Euclidean distance from w_in to each
// stored training vector, streamed serially from the training RAM.
module dist_classifier import face_pkg::*; #(
    parameter int unsigned  NUM_WEIGHTS = 400,
    parameter int unsigned  NUM_CLASSES = 16,
    parameter logic [31:0]  THRESH      = FP_POS_INF,
    localparam int unsigned ADDR_W      = $clog2(NUM_CLASSES * NUM_WEIGHTS),
    localparam int unsigned ID_W        = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_WEIGHTS-1:0][31:0]     w_in,
    output logic                             t_rd_en,
    output logic [ADDR_W-1:0]                t_addr,
    input  logic [31:0]                      t_data,
    output logic                             busy,
    output logic                             done,
    output logic [ID_W-1:0]                  match_id,
    output logic [31:0]                      match_dist,
    output logic                             match_valid
);

    localparam int unsigned KW      = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int unsigned LAT_MAX = (LAT_SUB > LAT_MUL) ?
                                      ((LAT_SUB > LAT_ADD) ? LAT_SUB : LAT_ADD) :
                                      ((LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD);
    localparam int unsigned WAIT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    state_t            state;
    logic [KW-1:0]     k;
    logic [ID_W-1:0]   c;
    logic [WAIT_W-1:0] waitCnt;
    logic [31:0]       opA, opB, acc, accOut, best, bestNext;
    logic [ID_W-1:0]   bestId, bestIdNext;
    logic              takeCur;

    fp_sqdiff_acc uDatapath (
        .clk(clk), .rst(rst), .a(opA), .b(opB), .acc_in(acc), .acc_out(accOut)
    );

    // Best-so-far update: class 0 always seeds it, later classes must be strictly closer
    always_comb begin
        takeCur    = (c == '0) || (acc < best);
        bestNext   = takeCur ? acc : best;
        bestIdNext = takeCur ? c : bestId;
    end

    // Sequencer; results are loaded on entry to DONE so they are valid with the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            c           <= '0;
            waitCnt     <= '0;
            opA         <= '0;
            opB         <= '0;
            acc         <= '0;
            best        <= '0;
            bestId      <= '0;
            t_rd_en     <= 1'b0;
            t_addr      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_id    <= '0;
            match_dist  <= '0;
            match_valid <= 1'b0;
        end else begin
            t_rd_en <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    state   <= FETCH;
                    k       <= '0;
                    c       <= '0;
                    acc     <= '0;
                    t_addr  <= '0;
                    t_rd_en <= 1'b1;
                    busy    <= 1'b1;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    opA     <= w_in[k];
                    opB     <= t_data;
                    waitCnt <= '0;
                    state   <= SUB;
                end
                SUB: if (waitCnt == WAIT_W'(LAT_SUB - 1)) begin
                    waitCnt <= '0;
                    state   <= MUL;
                end else begin
                    waitCnt <= waitCnt + WAIT_W'(1);
                end
                MUL: if (waitCnt == WAIT_W'(LAT_MUL - 1)) begin
                    waitCnt <= '0;
                    state   <= ACC;
                end else begin
                    waitCnt <= waitCnt + WAIT_W'(1);
                end
                ACC: if (waitCnt == WAIT_W'(LAT_ADD - 1)) begin
                    waitCnt <= '0;
                    state   <= NEXT;
                end else begin
                    waitCnt <= waitCnt + WAIT_W'(1);
                end
                NEXT: begin
                    acc <= accOut;
                    if (k == KW'(NUM_WEIGHTS - 1)) begin
                        state <= CMP;
                    end else begin
                        k       <= k + KW'(1);
                        t_addr  <= t_addr + ADDR_W'(1);
                        t_rd_en <= 1'b1;
                        state   <= FETCH;
                    end
                end
                CMP: begin
                    best   <= bestNext;
                    bestId <= bestIdNext;
                    if (c == ID_W'(NUM_CLASSES - 1)) begin
                        match_id    <= bestIdNext;
                        match_dist  <= bestNext;
                        match_valid <= bestNext <= THRESH;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        c       <= c + ID_W'(1);
                        k       <= '0;
                        acc     <= '0;
                        t_addr  <= t_addr + ADDR_W'(1);
                        t_rd_en <= 1'b1;
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
